pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RF_ADDRESS, default 5: register-index width.
REQ-002 Parameter NUM_SRC, default 2, legal 1..3: source operands per instruction.
REQ-003 Parameter FWD_EN, default 1: 1 = MEM/WB forwarding, 0 = interlock-only.
REQ-004 Parameter STALL_CNT_W, default 16: stall-counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 id_valid  in  1  ID stage holds a valid instruction.
REQ-008 id_rs  in  NUM_SRC*RF_ADDRESS  source register indices; source i at bits [i*RF_ADDRESS +: RF_ADDRESS].
REQ-009 id_rs_used  in  NUM_SRC  bit i set = source i is actually read.
REQ-010 id_rd  in  RF_ADDRESS  destination register.
REQ-011 id_regwrite  in  1  instruction writes the register file.
REQ-012 id_memread  in  1  instruction is a load.
REQ-013 ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
REQ-014 mem_ready  in  1  data memory done; 0 = MEM access still pending.
REQ-015 pc_stall  out  1  hold PC.
REQ-016 ifid_stall  out  1  hold IF/ID.
REQ-017 ifid_flush  out  1  zero IF/ID.
REQ-018 idex_bubble  out  1  load NOP into ID/EX.
REQ-019 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB; PC and IF/ID also held.
REQ-020 fwd_sel  out  NUM_SRC*2  per source of EX instruction: 00 = regfile/ID/EX value, 01 = WB, 10 = MEM ALU result.
REQ-021 stall_count  out  STALL_CNT_W  count of cycles with pc_stall=1.

Function
REQ-022 Shadow entries EX, MEM and WB SHALL each hold valid, rd, regwrite and memread; EX additionally holds rs[] and rs_used[].
REQ-023 With freeze=0, each edge SHALL shift WB<=MEM and MEM<=EX.
REQ-024 With freeze=0, EX SHALL load the ID fields when id_valid=1, idex_bubble=0 and ex_redirect=0; otherwise EX.valid<=0.
REQ-025 A match SHALL require: entry valid, regwrite=1, rd!=0, rd==id_rs[i], and id_rs_used[i]=1.
REQ-026 For FWD_EN=1, load-use SHALL be a match against EX with EX.memread=1, and SHALL assert pc_stall, ifid_stall and idex_bubble for exactly one cycle per load.
REQ-027 For FWD_EN=1, fwd_sel[i] SHALL be 10 on an EX.rs[i] match with MEM, else 01 on a match with WB, else 00; MEM takes priority.
REQ-028 For FWD_EN=0, any match against EX or MEM SHALL assert pc_stall, ifid_stall and idex_bubble, and fwd_sel SHALL be constant 0; the regfile is write-before-read, so WB needs no stall.
REQ-029 mem_ready=0 with MEM.valid=1 SHALL assert freeze, pc_stall and ifid_stall; all shadow entries SHALL hold; idex_bubble=0 and ifid_flush=0.
REQ-030 mem_ready is ignored when MEM.valid=0.
REQ-031 ex_redirect=1 with freeze=0 SHALL assert ifid_flush and idex_bubble and force pc_stall=ifid_stall=0, overriding any load-use or interlock stall.
REQ-032 ex_redirect during freeze SHALL have no effect until the first cycle with freeze=0; EX is held, so the redirect remains asserted.
REQ-033 Control outputs SHALL be combinational from shadow state and inputs, so ID stall decisions take effect in the same cycle.
REQ-034 stall_count SHALL increment by 1 on each edge where pc_stall=1, and SHALL saturate at 2^STALL_CNT_W-1 without wrapping.

Reset
REQ-035 While reset=1, every shadow valid SHALL be cleared on the edge and stall_count SHALL be set to 0.
REQ-036 While reset=1, all control outputs SHALL be 0 and fwd_sel SHALL be all 0, regardless of other inputs.
REQ-037 Reset asserted mid-freeze or mid-stall SHALL abort it; the first cycle after reset SHALL show no stall.

Verification
REQ-038 FWD_EN=1, lw x5 then add x6,x5,x7 -> exactly one cycle of pc_stall/idex_bubble; next cycle fwd_sel[0]=01; stall_count=1.
REQ-039 add x5 followed directly by sub x8,x5,x5 -> no stall; fwd_sel=1010. Same sequence with rd=x0 -> fwd_sel=0000.
REQ-040 FWD_EN=0, add x5 then add x6,x5,x1 -> two stall cycles; fwd_sel stays 0.
REQ-041 Load in MEM, mem_ready=0 for 3 cycles with ex_redirect=1 in EX -> freeze=1 for 3 cycles; flush/bubble on the 4th cycle; stall_count=3.
REQ-042 Load-use stall coincident with ex_redirect -> ifid_flush=1, idex_bubble=1, pc_stall=0.
REQ-043 STALL_CNT_W=2, 5 consecutive stall cycles -> stall_count saturates at 3; reset -> 0 with all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: tracks EX/MEM/WB destination
// shadows and drives stall, flush, bubble, freeze and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS  = 5,
  parameter int NUM_SRC     = 2,
  parameter int FWD_EN      = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [NUM_SRC*RF_ADDRESS-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]             id_rs_used,
  input  logic [RF_ADDRESS-1:0]          id_rd,
  input  logic                           id_regwrite,
  input  logic                           id_memread,
  input  logic                           ex_redirect,
  input  logic                           mem_ready,
  output logic                           pc_stall,
  output logic                           ifid_stall,
  output logic                           ifid_flush,
  output logic                           idex_bubble,
  output logic                           freeze,
  output logic [NUM_SRC*2-1:0]           fwd_sel,
  output logic [STALL_CNT_W-1:0]         stall_count
);

  // EX entry
  logic                          ex_valid_q, ex_valid_d;
  logic [RF_ADDRESS-1:0]         ex_rd_q, ex_rd_d;
  logic                          ex_regwrite_q, ex_regwrite_d;
  logic                          ex_memread_q, ex_memread_d;
  logic [NUM_SRC*RF_ADDRESS-1:0] ex_rs_q, ex_rs_d;
  logic [NUM_SRC-1:0]            ex_rs_used_q, ex_rs_used_d;
  // MEM and WB entries; only EX needs the load flag, since load-use is judged there
  logic                          mem_valid_q, mem_valid_d;
  logic [RF_ADDRESS-1:0]         mem_rd_q, mem_rd_d;
  logic                          mem_regwrite_q, mem_regwrite_d;
  logic                          wb_valid_q, wb_valid_d;
  logic [RF_ADDRESS-1:0]         wb_rd_q, wb_rd_d;
  logic                          wb_regwrite_q, wb_regwrite_d;

  logic [STALL_CNT_W-1:0]        stall_count_q, stall_count_d;

  logic                          ex_hit, mem_hit, interlock;
  logic [RF_ADDRESS-1:0]         id_src;
  logic [RF_ADDRESS-1:0]         ex_src;

  // ID source hits against in-flight producers
  always_comb begin
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    id_src  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_src = id_rs[i*RF_ADDRESS +: RF_ADDRESS];
      if (id_rs_used[i]) begin
        if (ex_valid_q && ex_regwrite_q && (ex_rd_q != '0) && (ex_rd_q == id_src))
          ex_hit = 1'b1;
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == id_src))
          mem_hit = 1'b1;
      end
    end
    if (FWD_EN != 0) interlock = ex_hit && ex_memread_q;
    else             interlock = ex_hit || mem_hit;
  end

  // Control outputs: freeze beats redirect, redirect beats any interlock stall
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    if (!reset) begin
      if (mem_valid_q && !mem_ready) begin
        freeze     = 1'b1;
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (interlock) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Forwarding selects for the instruction currently in EX; MEM wins over WB
  always_comb begin
    fwd_sel = '0;
    ex_src  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_src = ex_rs_q[i*RF_ADDRESS +: RF_ADDRESS];
      if ((FWD_EN != 0) && !reset && ex_valid_q && ex_rs_used_q[i]) begin
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_src))
          fwd_sel[i*2 +: 2] = 2'b10;
        else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_src))
          fwd_sel[i*2 +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    ex_rs_d        = ex_rs_q;
    ex_rs_used_d   = ex_rs_used_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_regwrite_d  = wb_regwrite_q;
    stall_count_d  = stall_count_q;
    if (!freeze) begin
      wb_valid_d     = mem_valid_q;
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      ex_valid_d     = id_valid && !idex_bubble && !ex_redirect;
      ex_rd_d        = id_rd;
      ex_regwrite_d  = id_regwrite;
      ex_memread_d   = id_memread;
      ex_rs_d        = id_rs;
      ex_rs_used_d   = id_rs_used;
    end
    if (pc_stall && (stall_count_q != {STALL_CNT_W{1'b1}}))
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_rs_q        <= '0;
      ex_rs_used_q   <= '0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      ex_rs_q        <= ex_rs_d;
      ex_rs_used_q   <= ex_rs_used_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations (forwarding, interlock-only,
// 2-bit counter) share one input stream and are each checked against a reference model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       ex_redirect;
  logic       mem_ready;

  logic [2:0]  pc_stall_w, ifid_stall_w, ifid_flush_w, idex_bubble_w, freeze_w;
  logic [3:0]  fwd_sel_w [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  logic [15:0] cnt_w [3];

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = cnt1;
  assign cnt_w[2] = {14'd0, cnt2};

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .NUM_SRC(2), .FWD_EN(1), .STALL_CNT_W(16)) u_dut_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall_w[0]), .ifid_stall(ifid_stall_w[0]), .ifid_flush(ifid_flush_w[0]),
    .idex_bubble(idex_bubble_w[0]), .freeze(freeze_w[0]), .fwd_sel(fwd_sel_w[0]),
    .stall_count(cnt0));

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .NUM_SRC(2), .FWD_EN(0), .STALL_CNT_W(16)) u_dut_ilk (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall_w[1]), .ifid_stall(ifid_stall_w[1]), .ifid_flush(ifid_flush_w[1]),
    .idex_bubble(idex_bubble_w[1]), .freeze(freeze_w[1]), .fwd_sel(fwd_sel_w[1]),
    .stall_count(cnt1));

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .NUM_SRC(2), .FWD_EN(1), .STALL_CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready),
    .pc_stall(pc_stall_w[2]), .ifid_stall(ifid_stall_w[2]), .ifid_flush(ifid_flush_w[2]),
    .idex_bubble(idex_bubble_w[2]), .freeze(freeze_w[2]), .fwd_sel(fwd_sel_w[2]),
    .stall_count(cnt2));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one in-flight instruction record per stage and configuration
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [9:0] rs;
    logic [1:0] used;
  } instr_t;

  instr_t      m_ex [3];
  instr_t      m_mem [3];
  instr_t      m_wb [3];
  int unsigned m_cnt [3];
  int          cfg_fwd [3] = '{1, 0, 1};
  int unsigned cfg_max [3] = '{65535, 65535, 3};

  logic e_ps [3], e_is [3], e_fl [3], e_bb [3], e_fz [3];
  logic [3:0] e_fs [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic produces(instr_t e, logic [4:0] r);
    return e.v && e.rw && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  task automatic predict(input int k);
    logic ex_hit, mem_hit, stall;
    logic [4:0] r;
    e_ps[k] = 0; e_is[k] = 0; e_fl[k] = 0; e_bb[k] = 0; e_fz[k] = 0; e_fs[k] = 4'd0;
    if (!reset) begin
      ex_hit = 0;
      mem_hit = 0;
      for (int i = 0; i < 2; i++) begin
        r = id_rs[i*5 +: 5];
        if (id_rs_used[i] && produces(m_ex[k], r))  ex_hit = 1;
        if (id_rs_used[i] && produces(m_mem[k], r)) mem_hit = 1;
      end
      stall = (cfg_fwd[k] != 0) ? (ex_hit && m_ex[k].mr) : (ex_hit || mem_hit);
      if (m_mem[k].v && !mem_ready) begin
        e_fz[k] = 1; e_ps[k] = 1; e_is[k] = 1;
      end else if (ex_redirect) begin
        e_fl[k] = 1; e_bb[k] = 1;
      end else if (stall) begin
        e_ps[k] = 1; e_is[k] = 1; e_bb[k] = 1;
      end
      if (cfg_fwd[k] != 0) begin
        for (int i = 0; i < 2; i++) begin
          r = m_ex[k].rs[i*5 +: 5];
          if (m_ex[k].v && m_ex[k].used[i]) begin
            if (produces(m_mem[k], r))     e_fs[k][i*2 +: 2] = 2'b10;
            else if (produces(m_wb[k], r)) e_fs[k][i*2 +: 2] = 2'b01;
          end
        end
      end
    end
  endtask

  task automatic advance(input int k);
    instr_t n;
    if (reset) begin
      m_ex[k].v = 0; m_mem[k].v = 0; m_wb[k].v = 0;
      m_cnt[k] = 0;
    end else begin
      if (e_ps[k] && m_cnt[k] < cfg_max[k]) m_cnt[k]++;
      if (!e_fz[k]) begin
        n.v = id_valid && !e_bb[k] && !ex_redirect;
        n.rd = id_rd; n.rw = id_regwrite; n.mr = id_memread;
        n.rs = id_rs; n.used = id_rs_used;
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        m_ex[k]  = n;
      end
    end
  endtask

  // driver: apply one cycle of inputs, check after settling, advance model at the edge
  task automatic step(input logic r, input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic rdr, input logic mrdy);
    reset = r; id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
    id_regwrite = rw; id_memread = mr; ex_redirect = rdr; mem_ready = mrdy;
    #1;
    for (int k = 0; k < 3; k++) begin
      predict(k);
      check($sformatf("c%0d_pc_stall", k),    {31'd0, pc_stall_w[k]},    {31'd0, e_ps[k]});
      check($sformatf("c%0d_ifid_stall", k),  {31'd0, ifid_stall_w[k]},  {31'd0, e_is[k]});
      check($sformatf("c%0d_ifid_flush", k),  {31'd0, ifid_flush_w[k]},  {31'd0, e_fl[k]});
      check($sformatf("c%0d_idex_bubble", k), {31'd0, idex_bubble_w[k]}, {31'd0, e_bb[k]});
      check($sformatf("c%0d_freeze", k),      {31'd0, freeze_w[k]},      {31'd0, e_fz[k]});
      check($sformatf("c%0d_fwd_sel", k),     {28'd0, fwd_sel_w[k]},     {28'd0, e_fs[k]});
      check($sformatf("c%0d_stall_count", k), {16'd0, cnt_w[k]},         m_cnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) advance(k);
    @(negedge clk);
  endtask

  task automatic rst_cycle();
    step(1, 1, 5'd5, 5'd5, 2'b11, 5'd5, 1, 1, 1, 0);
  endtask

  task automatic op(input logic [4:0] rd, input logic rw, input logic mr,
                    input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    step(0, 1, rs0, rs1, used, rd, rw, mr, 0, 1);
  endtask

  task automatic nop();
    step(0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_regwrite = 0; id_memread = 0; ex_redirect = 0; mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0;
    end
    @(posedge clk);
    @(negedge clk);

    // lw x5 ; add x6,x5,x7 held in ID while the load-use stall lasts
    rst_cycle();
    op(5'd5, 1, 1, 5'd0, 5'd0, 2'b00);
    op(5'd6, 1, 0, 5'd5, 5'd7, 2'b11);
    op(5'd6, 1, 0, 5'd5, 5'd7, 2'b11);
    nop();
    check("lw_add_stall_count", {16'd0, cnt0}, 32'd1);

    // add x5 ; sub x8,x5,x5, then the same with x0 as destination
    rst_cycle();
    op(5'd5, 1, 0, 5'd1, 5'd2, 2'b11);
    op(5'd8, 1, 0, 5'd5, 5'd5, 2'b11);
    nop(); nop();
    rst_cycle();
    op(5'd0, 1, 0, 5'd1, 5'd2, 2'b11);
    op(5'd8, 1, 0, 5'd0, 5'd0, 2'b11);
    nop(); nop();

    // add x5 ; add x6,x5,x1 under interlock-only
    rst_cycle();
    op(5'd5, 1, 0, 5'd1, 5'd2, 2'b11);
    op(5'd6, 1, 0, 5'd5, 5'd1, 2'b11);
    op(5'd6, 1, 0, 5'd5, 5'd1, 2'b11);
    op(5'd6, 1, 0, 5'd5, 5'd1, 2'b11);
    nop();
    check("ilk_stall_count", {16'd0, cnt1}, 32'd2);

    // load in MEM stalled 3 cycles while a redirect waits in EX
    rst_cycle();
    op(5'd5, 1, 1, 5'd0, 5'd0, 2'b00);
    op(5'd0, 0, 0, 5'd1, 5'd2, 2'b11);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd3, 5'd4, 2'b11, 5'd9, 1, 0, 1, 0);
    step(0, 1, 5'd3, 5'd4, 2'b11, 5'd9, 1, 0, 1, 1);
    check("freeze_stall_count", {16'd0, cnt0}, 32'd3);
    nop();

    // load-use coinciding with a redirect
    rst_cycle();
    op(5'd5, 1, 1, 5'd0, 5'd0, 2'b00);
    step(0, 1, 5'd5, 5'd7, 2'b11, 5'd6, 1, 0, 1, 1);
    nop();

    // five freeze cycles saturate the 2-bit counter; reset then clears it
    rst_cycle();
    op(5'd5, 1, 1, 5'd0, 5'd0, 2'b00);
    nop();
    for (int i = 0; i < 5; i++) step(0, 1, 5'd5, 5'd5, 2'b11, 5'd5, 1, 1, 1, 0);
    check("sat_count_w2", {30'd0, cnt2}, 32'd3);
    check("sat_count_w16", {16'd0, cnt0}, 32'd5);
    rst_cycle();
    check("post_reset_count", {30'd0, cnt2}, 32'd0);
    nop();

    // randomized traffic with a small register pool to force frequent hazards
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 8,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 1,
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
